// File: rtl/keypad_scanner_if.sv
// Key-event handshake between the keypad scanner (master) and the consumer of key codes (slave).
interface keypad_scanner_if #(
  parameter int KW = 4
);
  logic [KW-1:0] key_code;
  logic          key_valid;
  logic          key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row drive, column sync, per-frame single-key resolution,
// frame-level debounce and a small press-event FIFO behind a valid/ready handshake.
module keypad_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int KW        = $clog2(ROWS*COLS)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [ROWS-1:0]     row_n,
  input  logic [COLS-1:0]     col_n,
  keypad_scanner_if.master    key_if,
  output logic                key_held,
  output logic [KW-1:0]       held_code,
  output logic                overflow,
  input  logic                ovf_clr
);

  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(SCAN_DIV);
  localparam int CLW = $clog2(COLS);
  localparam int DW  = $clog2(DEBOUNCE + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE);

  typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_t;

  // ---------------- row scan ----------------
  logic [CW-1:0] dwell;
  logic [RW-1:0] row;
  logic          sample;
  logic          last_row;

  assign sample   = (dwell == CW'(SCAN_DIV - 1));
  assign last_row = (row == RW'(ROWS - 1));
  assign row_n    = ~(ROWS'(1) << row);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell <= '0;
      row   <= '0;
    end else if (sample) begin
      dwell <= '0;
      row   <= last_row ? '0 : row + RW'(1);
    end else begin
      dwell <= dwell + CW'(1);
    end
  end

  // ---------------- column synchroniser ----------------
  logic [COLS-1:0] col_s1, col_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1 <= '1;
      col_s2 <= '1;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
    end
  end

  // ---------------- per-row evaluation ----------------
  logic [COLS-1:0] low_v;
  logic [COLS-1:0] shifted;
  logic [1:0]      row_hits;
  logic [CLW-1:0]  low_col;

  // Scan high to low so the last match left standing is the lowest column.
  always_comb begin
    low_v    = ~col_s2;
    shifted  = '0;
    row_hits = '0;
    low_col  = '0;
    for (int unsigned c = COLS; c > 0; c--) begin
      shifted = low_v >> (c - 1);
      if (shifted[0]) begin
        low_col = CLW'(c - 1);
        if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
      end
    end
  end

  // ---------------- frame accumulation ----------------
  logic [1:0]    acc_hits;
  logic [KW-1:0] acc_idx;
  logic [2:0]    hit_sum;
  logic [1:0]    frame_hits;
  logic [KW-1:0] cur_idx;
  logic [KW-1:0] frame_idx;
  res_t          res_kind;
  logic [KW-1:0] res_idx;

  assign cur_idx    = KW'(row) * KW'(COLS) + KW'(low_col);
  assign hit_sum    = {1'b0, acc_hits} + {1'b0, row_hits};
  assign frame_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
  assign frame_idx  = (acc_hits == 2'd0) ? cur_idx : acc_idx;

  always_comb begin
    res_kind = RES_NONE;
    res_idx  = '0;
    if (frame_hits == 2'd1) begin
      res_kind = RES_KEY;
      res_idx  = frame_idx;
    end else if (frame_hits == 2'd2) begin
      res_kind = RES_MULTI;
    end
  end

  // ---------------- debounce / accepted state ----------------
  res_t          prev_kind;
  logic [KW-1:0] prev_idx;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_next;
  logic          differs;
  logic          accept;
  logic          push_req;

  assign deb_next = ((res_kind != prev_kind) || (res_idx != prev_idx)) ? DW'(1) :
                    (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + DW'(1);

  // key_held/held_code are themselves the accepted state (NONE when !key_held).
  assign differs = (res_kind == RES_KEY) ? (!key_held || (res_idx != held_code)) : key_held;
  assign accept  = (deb_next == DEB_MAX) && (res_kind != RES_MULTI) && differs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hits  <= '0;
      acc_idx   <= '0;
      prev_kind <= RES_NONE;
      prev_idx  <= '0;
      deb_cnt   <= '0;
      key_held  <= 1'b0;
      held_code <= '0;
      push_req  <= 1'b0;
    end else begin
      push_req <= 1'b0;
      if (sample) begin
        if (last_row) begin
          acc_hits  <= '0;
          acc_idx   <= '0;
          prev_kind <= res_kind;
          prev_idx  <= res_idx;
          deb_cnt   <= deb_next;
          if (accept) begin
            key_held <= (res_kind == RES_KEY);
            if (res_kind == RES_KEY) begin
              held_code <= res_idx;
              push_req  <= 1'b1;
            end
          end
        end else begin
          acc_hits <= frame_hits;
          acc_idx  <= frame_idx;
        end
      end
    end
  end

  // ---------------- event FIFO ----------------
  logic [KW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_valid;
  logic          full;
  logic          pop;
  logic          do_push;

  assign fifo_valid = (count != '0);
  assign full       = (count == FULL_CNT);
  assign pop        = fifo_valid && key_if.key_ready;
  // held_code is stable for the cycle push_req is high, so it doubles as push data.
  assign do_push    = push_req && (!full || pop);

  assign key_if.key_valid = fifo_valid;
  assign key_if.key_code  = fifo_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= held_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(pop);
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (ovf_clr)             overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model drives col_n from row_n, and a
// frame-level behavioural model predicts every output each cycle.
module tb_keypad_scanner;

  localparam int KW  = 4;
  localparam int SD  = 4;
  localparam int NR  = 4;
  localparam int F   = SD * NR;
  localparam int DEB = 2;
  localparam int FD  = 2;

  logic          clk;
  logic          rst_n;
  logic [3:0]    row_n;
  logic [3:0]    col_n;
  logic          key_held;
  logic [KW-1:0] held_code;
  logic          overflow;
  logic          ovf_clr;
  logic          key_ready;
  logic [15:0]   pressed;
  bit            chk_en;

  int checks = 0;
  int errors = 0;

  keypad_scanner_if #(.KW(KW)) kif ();
  assign kif.key_ready = key_ready;

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(SD), .DEBOUNCE(DEB), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n), .key_if(kif),
    .key_held(key_held), .held_code(held_code), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its column to its row line.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < 4; r++)
      if (!row_n[r])
        for (int c = 0; c < 4; c++)
          if (pressed[r*4 + c]) col_n[c] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned mc;      // index of the current cycle since reset release
  int          hist[$]; // most recent frame results, newest last
  int          q[$];    // expected FIFO contents
  bit          m_held;
  int          m_code;
  bit          m_ovf;
  bit          m_push;
  bit          m_pop, m_drop, m_stable;
  int          m_res;

  // -1 = no key, -2 = several keys, else the single key's index
  function automatic int frame_result(input logic [15:0] p);
    int n = 0;
    int first = -1;
    for (int k = 0; k < 16; k++)
      if (p[k]) begin
        n++;
        if (first < 0) first = k;
      end
    if (n == 0) return -1;
    if (n > 1) return -2;
    return first;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc = 0; hist.delete(); q.delete();
      m_held = 0; m_code = 0; m_ovf = 0; m_push = 0;
    end else begin
      m_pop  = (q.size() > 0) && key_ready;
      m_drop = m_push && (q.size() == FD) && !m_pop;
      if (m_pop) void'(q.pop_front());
      if (m_push && !m_drop) q.push_back(m_code);
      if (m_drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      m_push = 0;
      if (mc % F == F - 1) begin
        m_res = frame_result(pressed);
        hist.push_back(m_res);
        if (hist.size() > DEB) void'(hist.pop_front());
        m_stable = (hist.size() == DEB);
        foreach (hist[i]) if (hist[i] != m_res) m_stable = 0;
        if (m_stable && m_res != -2 && m_res != (m_held ? m_code : -1)) begin
          if (m_res == -1) m_held = 0;
          else begin
            m_held = 1; m_code = m_res; m_push = 1;
          end
        end
      end
      mc++;
    end
  end

  logic [3:0] exp_row;
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      exp_row = ~(4'b0001 << ((mc / SD) % NR));
      check("row_n", int'(row_n), int'(exp_row));
      check("key_valid", int'(kif.key_valid), int'(q.size() > 0));
      if (q.size() > 0) check("key_code", int'(kif.key_code), q[0]);
      check("key_held", int'(key_held), int'(m_held));
      if (m_held) check("held_code", int'(held_code), m_code);
      check("overflow", int'(overflow), int'(m_ovf));
    end
  end

  // ---------------- stimulus ----------------
  task automatic sync_frame();
    int guard = 0;
    @(posedge clk); #1;
    while ((mc % F) != 0 && guard < 4 * F) begin
      @(posedge clk); #1;
      guard++;
    end
    check("frame_align", int'(mc % F), 0);
  endtask

  task automatic frames(input int n);
    repeat (n * F) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    key_ready = 1'b1;
    @(posedge clk); #1;
    key_ready = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_row_n", int'(row_n), 4'b1110);
    check("rst_key_valid", int'(kif.key_valid), 0);
    check("rst_key_code", int'(kif.key_code), 0);
    check("rst_key_held", int'(key_held), 0);
    check("rst_held_code", int'(held_code), 0);
    check("rst_overflow", int'(overflow), 0);
  endtask

  // Called right after rst_n release, inside cycle 0.
  task automatic row_seq_check();
    logic [3:0] seq [4];
    seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("row_seq", int'(row_n), int'(seq[i/4]));
    end
  endtask

  int nfr, bias;

  initial begin
    rst_n = 1'b0; key_ready = 1'b0; ovf_clr = 1'b0; pressed = '0; chk_en = 0;
    repeat (3) @(posedge clk);
    #1 check_reset_values();
    @(posedge clk); #2 rst_n = 1'b1; chk_en = 1;
    row_seq_check();

    // single press of row 2 / col 1
    sync_frame();
    pressed = 16'h0200;
    frames(3);
    check("press_valid", int'(kif.key_valid), 1);
    check("press_code", int'(kif.key_code), 9);
    check("press_held", int'(key_held), 1);
    check("press_held_code", int'(held_code), 9);
    pressed = '0;
    frames(2);
    check("release_held", int'(key_held), 0);
    check("release_valid", int'(kif.key_valid), 1);
    check("release_code", int'(kif.key_code), 9);
    pop_one();
    check("release_drained", int'(kif.key_valid), 0);

    // bounce
    sync_frame();
    for (int f = 0; f < 6; f++) begin
      pressed = (f % 2 == 0) ? 16'h0200 : 16'h0000;
      frames(1);
    end
    check("bounce_valid", int'(kif.key_valid), 0);
    check("bounce_held", int'(key_held), 0);

    // ghost / multi
    pressed = 16'h0021;
    frames(4);
    check("multi_valid", int'(kif.key_valid), 0);
    check("multi_held", int'(key_held), 0);
    pressed = 16'h0001;
    frames(3);
    check("multi_rel_valid", int'(kif.key_valid), 1);
    check("multi_rel_code", int'(kif.key_code), 0);
    check("multi_rel_held", int'(key_held), 1);
    pressed = '0;
    frames(2);
    pop_one();

    // overflow
    sync_frame();
    for (int k = 3; k < 12; k += 4) begin
      pressed = 16'(1) << k;
      frames(3);
      pressed = '0;
      frames(2);
    end
    check("ovf_flag", int'(overflow), 1);
    check("ovf_head0", int'(kif.key_code), 3);
    pop_one();
    check("ovf_head1", int'(kif.key_code), 7);
    check("ovf_valid1", int'(kif.key_valid), 1);
    pop_one();
    check("ovf_empty", int'(kif.key_valid), 0);
    check("ovf_still_set", int'(overflow), 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    check("ovf_cleared", int'(overflow), 0);

    // reset in the middle of a debounce
    sync_frame();
    pressed = 16'h0040;
    frames(1);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_values();
    @(posedge clk); #2 rst_n = 1'b1;
    row_seq_check();
    sync_frame();
    pressed = '0;
    frames(3);
    check("midrst_valid", int'(kif.key_valid), 0);
    check("midrst_held", int'(key_held), 0);

    // randomized presses with random consumer back-pressure
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0, 1:    pressed = '0;
        2, 3, 4: pressed = 16'(1) << $urandom_range(0, 15);
        default: pressed = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      endcase
      nfr  = $urandom_range(1, 4);
      bias = $urandom_range(0, 3);
      repeat (nfr * F) begin
        @(posedge clk); #1;
        key_ready = ($urandom_range(0, 3) < bias);
        ovf_clr   = ($urandom_range(0, 15) == 0);
      end
    end
    key_ready = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    chk_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
